// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampling, small receive FIFO
module uart_rx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun
);
    localparam int DIV   = (CLK_HZ + BAUD * 8) / (BAUD * 16);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    logic             sync1_q, sync1_d;
    logic             rxs_q, rxs_d;
    logic [1:0]       sync_vld_q, sync_vld_d;
    logic             prev_q, prev_d;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [3:0]       sc_q, sc_d;
    logic [2:0]       bc_q, bc_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic tick;
    logic push_req;
    logic push;
    logic pop;
    logic full;

    always_comb begin
        sync1_d    = rx;
        rxs_d      = sync1_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        // prev only tracks rxs once the synchroniser holds real line data, so a
        // line held low out of reset never looks like a falling edge
        prev_d     = sync_vld_q[1] ? rxs_q : 1'b0;

        tick       = (div_cnt_q == DIV_MAX);
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);

        state_d     = state_q;
        sc_d        = sc_q;
        bc_d        = bc_q;
        shift_d     = shift_q;
        push_req    = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (prev_q && !rxs_q) begin
                    state_d   = START;
                    sc_d      = '0;
                    div_cnt_d = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (sc_q == 4'd7) begin
                        if (!rxs_q) begin
                            state_d = DATA;
                            sc_d    = '0;
                            bc_d    = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (sc_q == 4'd15) begin
                        shift_d = {rxs_q, shift_q[7:1]};
                        sc_d    = '0;
                        if (bc_q == 3'd7) begin
                            state_d = STOP;
                        end else begin
                            bc_d = bc_q + 3'd1;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sc_q == 4'd15) begin
                        if (rxs_q) begin
                            push_req = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end
                    end else begin
                        sc_d = sc_q + 4'd1;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop       = valid_q & i_ready;
        full      = (count_q == FULL_CNT);
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        push      = push_req & (~full | pop);
        overrun_d = push_req & full & ~pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = shift_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        valid_d = (count_d != '0);
        data_d  = valid_d ? mem_d[rd_ptr_d] : 8'h00;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            sync_vld_q  <= '0;
            prev_q      <= 1'b0;
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            sc_q        <= '0;
            bc_q        <= '0;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rxs_q       <= rxs_d;
            sync_vld_q  <= sync_vld_d;
            prev_q      <= prev_d;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            sc_q        <= sc_d;
            bc_q        <= bc_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
    localparam int BIT_CYC = 16;
    // start-edge drive to stop-bit sample: 2 sync flops + edge detect + 9.5 bits
    localparam int PUSH_OFS = 154;
    localparam int NV = 7;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       glitch;
        int         exp_n;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;

    int         total;
    int         bad;
    int         cyc = 0;
    int         start_cyc;
    logic [7:0] got_q[$];
    int         pop_cyc_q[$];
    int         valid_cnt = 0;
    int         ferr_cnt = 0;
    int         ovr_cnt = 0;
    logic       ferr_prev = 1'b0;
    logic       ovr_prev = 1'b0;
    logic       hold_pend = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic       rnd_done;
    vec_t       vecs[NV];
    logic [7:0] exp_q[$];
    int         ferr_exp;

    uart_rx #(
        .CLK_HZ    (1_600_000),
        .BAUD      (100_000),
        .FIFO_DEPTH(4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .rx         (rx),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (ready),
        .o_frame_err(o_frame_err),
        .o_overrun  (o_overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (o_valid) valid_cnt++;
        if (o_valid && ready) begin
            got_q.push_back(o_data);
            pop_cyc_q.push_back(cyc);
        end
        if (hold_pend && o_valid) check("data_hold", o_data, hold_data);
        hold_pend = o_valid && !ready;
        hold_data = o_data;
        if (o_frame_err) begin
            ferr_cnt++;
            check("ferr_width", int'(ferr_prev), 0);
        end
        if (o_overrun) begin
            ovr_cnt++;
            check("ovr_width", int'(ovr_prev), 0);
        end
        ferr_prev = o_frame_err;
        ovr_prev  = o_overrun;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        step(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(BIT_CYC);
        end
        rx = stop;
        step(BIT_CYC);
        rx = 1'b1;
    endtask

    task automatic clear_obs();
        got_q.delete();
        pop_cyc_q.delete();
        valid_cnt = 0;
        ferr_cnt  = 0;
        ovr_cnt   = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] b2b_exp[6];
        logic [7:0] d;
        logic       stop;
        total = 0;
        bad   = 0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 0, 8'h00, 0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 0, 8'h00, 1};
        vecs[3] = '{8'h55, 1'b1, 1'b0, 1, 8'h55, 0};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 1, 8'h00, 0};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 0};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 0, 8'h00, 1};

        // line held low through and after reset must not start a frame
        rst = 1'b1;
        rx  = 1'b0;
        step(4);
        rst = 1'b0;
        step(40);
        rx = 1'b1;
        step(200);
        check("lowrst_bytes", got_q.size(), 0);
        check("lowrst_ferr", ferr_cnt, 0);

        rst = 1'b1;
        step(2);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_ferr", o_frame_err, 0);
        check("rst_ovr", o_overrun, 0);
        rst = 1'b0;
        step(5);

        for (int i = 0; i < NV; i++) begin
            clear_obs();
            start_cyc = cyc;
            if (vecs[i].glitch) begin
                rx = 1'b0;
                step(4);
                rx = 1'b1;
            end else begin
                send_frame(vecs[i].data, vecs[i].stop);
            end
            step(40);
            check($sformatf("v%0d_count", i), got_q.size(), vecs[i].exp_n);
            check($sformatf("v%0d_valid_cycles", i), valid_cnt, vecs[i].exp_n);
            check($sformatf("v%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
            check($sformatf("v%0d_ovr", i), ovr_cnt, 0);
            if (vecs[i].exp_n > 0 && got_q.size() > 0) begin
                check($sformatf("v%0d_data", i), got_q[0], vecs[i].exp_data);
                check($sformatf("v%0d_latency_le160", i),
                      int'((pop_cyc_q[0] - start_cyc) <= 160), 1);
            end
        end

        // overrun: FIFO of 4 fills, 5th byte dropped
        ready = 1'b0;
        clear_obs();
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1);
            step(2);
            if (k == 4) check("ovr_after4", ovr_cnt, 0);
        end
        step(20);
        check("ovr_after5", ovr_cnt, 1);
        check("ovr_head_valid", o_valid, 1);
        check("ovr_head_data", o_data, 8'h01);
        ready = 1'b1;
        step(10);
        check("ovr_drain_count", got_q.size(), 4);
        for (int k = 0; k < 4 && k < got_q.size(); k++)
            check($sformatf("ovr_drain%0d", k), got_q[k], k + 1);
        check("ovr_drain_empty", o_valid, 0);

        // reset in the middle of 0x99 flushes FIFO and partial frame
        ready = 1'b0;
        clear_obs();
        send_frame(8'h11, 1'b1);
        step(10);
        check("pre_rst_valid", o_valid, 1);
        check("pre_rst_data", o_data, 8'h11);
        rx = 1'b0;
        step(BIT_CYC);
        rx = 1'b1;
        step(BIT_CYC);
        rx = 1'b0;
        step(2 * BIT_CYC);
        rx = 1'b1;
        step(BIT_CYC / 2);
        rst = 1'b1;
        step(2);
        check("midrst_valid", o_valid, 0);
        check("midrst_data", o_data, 0);
        rst   = 1'b0;
        ready = 1'b1;
        step(200);
        check("midrst_bytes", got_q.size(), 0);
        check("midrst_ferr", ferr_cnt, 0);
        clear_obs();
        send_frame(8'h7E, 1'b1);
        step(20);
        check("post_rst_count", got_q.size(), 1);
        if (got_q.size() > 0) check("post_rst_data", got_q[0], 8'h7E);

        // back-to-back frames into a full FIFO, popped on each push cycle
        ready = 1'b0;
        clear_obs();
        for (int k = 0; k < 4; k++) send_frame(8'hC1 + 8'(k), 1'b1);
        step(5);
        check("b2b_full_valid", o_valid, 1);
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                step(PUSH_OFS);
                ready = 1'b1;
                step(1);
                ready = 1'b0;
                step(BIT_CYC * 10 - 1);
                ready = 1'b1;
                step(1);
                ready = 1'b0;
            end
        join
        step(10);
        check("b2b_ovr", ovr_cnt, 0);
        check("b2b_popped", got_q.size(), 2);
        ready = 1'b1;
        step(10);
        b2b_exp = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'h00, 8'hFF};
        check("b2b_count", got_q.size(), 6);
        for (int k = 0; k < 6 && k < got_q.size(); k++)
            check($sformatf("b2b_byte%0d", k), got_q[k], b2b_exp[k]);
        check("b2b_empty", o_valid, 0);

        // randomized frames against a byte-queue model, ready toggled randomly
        clear_obs();
        exp_q.delete();
        ferr_exp = 0;
        rnd_done = 1'b0;
        fork
            begin
                while (!rnd_done) begin
                    ready = 1'($urandom_range(0, 1));
                    step(1);
                end
            end
            begin
                for (int n = 0; n < 16; n++) begin
                    d    = 8'($urandom);
                    stop = ($urandom_range(0, 7) != 0);
                    if (stop) exp_q.push_back(d);
                    else ferr_exp++;
                    send_frame(d, stop);
                    step(stop ? $urandom_range(0, 20) : $urandom_range(4, 20));
                end
                step(40);
                rnd_done = 1'b1;
            end
        join
        ready = 1'b1;
        step(20);
        check("rnd_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("rnd_byte%0d", k), got_q[k], exp_q[k]);
        check("rnd_ferr", ferr_cnt, ferr_exp);
        check("rnd_ovr", ovr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
